// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction-fetch front end between the icache and the
// RVC decompressor. Fetches word-aligned 32-bit words, keeps them as a
// four-slot halfword buffer and presents one 16- or 32-bit instruction per
// cycle, including instructions that straddle a word boundary.
//
// Ports:
//   clk_in, rstn_in        clock, asynchronous active-low reset
//   req_valid/req_addr     registered word-aligned fetch request to icache
//   req_ready              icache accepts the request this cycle
//   resp_valid/resp_data   one-cycle icache response, little-endian halfwords
//   flush_in/flush_pc      redirect from backend (flush_pc bit 0 ignored)
//   instr_valid/instr_ready  instruction handshake with the decompressor
//   instr_out/instr_pc     raw instruction (upper half zero if compressed), PC
//   instr_is_c             instruction is 16-bit
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | no request outstanding; issue one when cnt <= 2
// REQ          | req_valid held with stable req_addr until req_ready
// WAIT         | request accepted; next resp_valid is appended
// WAIT_DISCARD | request accepted before a flush; next resp_valid is dropped

module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WAIT_DISCARD} state_t;

  state_t      state;
  logic [15:0] slots [4];
  logic [2:0]  cnt;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        drop_low;

  logic [15:0] slot0;
  logic [15:0] slot1;
  logic        consume;
  logic        append;
  logic [2:0]  n_consumed;
  logic [2:0]  n_appended;
  logic [2:0]  wr_base;
  logic [2:0]  cnt_next;
  logic [15:0] slots_next [4];

  // Redirect targets are halfword aligned; the LSB carries no information.
  logic unused_flush_lsb;
  assign unused_flush_lsb = flush_pc[0];

  assign slot0       = slots[0];
  assign slot1       = slots[1];
  assign instr_is_c  = (slot0[1:0] != 2'b11);
  assign instr_valid = (cnt >= 3'd2) || ((cnt != 3'd0) && instr_is_c);
  assign instr_out   = instr_is_c ? {16'h0000, slot0} : {slot1, slot0};
  assign instr_pc    = pc;

  assign consume    = instr_valid && instr_ready && !flush_in;
  assign append     = (state == WAIT) && resp_valid && !flush_in;
  assign n_consumed = !consume ? 3'd0 : (instr_is_c ? 3'd1 : 3'd2);
  assign n_appended = !append ? 3'd0 : (drop_low ? 3'd1 : 3'd2);
  // Requests are only issued at cnt <= 2, so wr_base never exceeds 2 and
  // both appended halfwords always land inside the four slots.
  assign wr_base    = cnt - n_consumed;
  assign cnt_next   = wr_base + n_appended;

  always_comb begin
    for (int i = 0; i < 4; i++) slots_next[i] = slots[i];
    if (n_consumed == 3'd1) begin
      for (int i = 0; i < 3; i++) slots_next[i] = slots[i+1];
    end else if (n_consumed == 3'd2) begin
      for (int i = 0; i < 2; i++) slots_next[i] = slots[i+2];
    end
    if (append) begin
      if (drop_low) begin
        slots_next[wr_base[1:0]] = resp_data[31:16];
      end else begin
        slots_next[wr_base[1:0]]        = resp_data[15:0];
        slots_next[wr_base[1:0] + 2'd1] = resp_data[31:16];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state      <= IDLE;
      req_valid  <= 1'b0;
      req_addr   <= 32'h0;
      cnt        <= 3'd0;
      pc         <= {RESET_PC[31:1], 1'b0};
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      drop_low   <= RESET_PC[1];
      for (int i = 0; i < 4; i++) slots[i] <= 16'h0;
    end else if (flush_in) begin
      cnt        <= 3'd0;
      pc         <= {flush_pc[31:1], 1'b0};
      fetch_addr <= {flush_pc[31:2], 2'b00};
      drop_low   <= flush_pc[1];
      req_valid  <= 1'b0;
      case (state)
        // A request accepted in the flush cycle still gets a response.
        REQ:          state <= req_ready ? WAIT_DISCARD : IDLE;
        // A response arriving together with the flush is the stale one.
        WAIT:         state <= resp_valid ? IDLE : WAIT_DISCARD;
        // Same reasoning: a coincident response retires the stale request,
        // otherwise nothing would ever answer the WAIT_DISCARD.
        WAIT_DISCARD: state <= resp_valid ? IDLE : WAIT_DISCARD;
        default:      state <= IDLE;
      endcase
    end else begin
      slots <= slots_next;
      cnt   <= cnt_next;
      if (consume) pc <= pc + (instr_is_c ? 32'd2 : 32'd4);
      if (append) begin
        fetch_addr <= fetch_addr + 32'd4;
        drop_low   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cnt <= 3'd2) begin
            req_valid <= 1'b1;
            req_addr  <= fetch_addr;
            state     <= REQ;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (resp_valid) state <= IDLE;
        end
        WAIT_DISCARD: begin
          if (resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk_in = 1'b0;
  logic        rstn_in = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        flush_in = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_is_c;

  always #5 clk_in = ~clk_in;

  fetch_aligner #(.RESET_PC(RST_PC)) dut (
    .clk_in      (clk_in),
    .rstn_in     (rstn_in),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .flush_in    (flush_in),
    .flush_pc    (flush_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_is_c  (instr_is_c)
  );

  int total = 0;
  int bad   = 0;

  // Memory image: explicit words override a hash of the address.
  logic [31:0] mem [logic [31:0]];

  // icache / stream model state
  int          ir_prob = 100;
  int          rr_prob = 100;
  int          lat_lo  = 1;
  int          lat_hi  = 1;
  int          cyc     = 0;
  bit          pend    = 0;
  bit          pend_live = 0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_fa = 32'h0;
  bit          flushed_last = 0;
  int          n_cons = 0;

  logic [31:0] obs_instr [$];
  logic [31:0] obs_pc [$];
  logic        obs_c [$];
  int          obs_cyc [$];
  logic [31:0] req_log [$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ (w >> 7) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_instr.delete();
    obs_pc.delete();
    obs_c.delete();
    obs_cyc.delete();
  endtask

  // One clock cycle: at the falling edge, check outputs, drive the next
  // inputs and advance the reference model for what the rising edge does.
  task automatic tick(input bit do_flush, input logic [31:0] tgt);
    bit          deliver;
    bit          accept;
    logic [15:0] h0;
    logic [15:0] h1;
    logic [31:0] e_instr;
    bit          e_c;
    @(negedge clk_in);
    cyc++;
    deliver = 0;
    if (flushed_last) chk("valid_after_flush", {31'b0, instr_valid}, 32'h0);
    flushed_last = do_flush;
    if (req_valid) begin
      chk("one_outstanding", {31'b0, pend}, 32'h0);
      chk("req_align", {30'b0, req_addr[1:0]}, 32'h0);
    end
    resp_valid = 1'b0;
    resp_data  = $urandom();
    if (pend) begin
      if (pend_cnt == 0) begin
        resp_valid = 1'b1;
        resp_data  = word_at(pend_addr);
        deliver    = 1;
      end else begin
        pend_cnt--;
      end
    end
    req_ready   = ($urandom_range(99) < rr_prob);
    accept      = req_valid && req_ready;
    flush_in    = do_flush;
    flush_pc    = do_flush ? tgt : $urandom();
    instr_ready = ($urandom_range(99) < ir_prob);
    if (!do_flush && instr_valid && instr_ready) begin
      h0  = hw_at(exp_pc);
      e_c = (h0[1:0] != 2'b11);
      if (e_c) begin
        e_instr = {16'h0000, h0};
      end else begin
        h1 = hw_at(exp_pc + 32'd2);
        e_instr = {h1, h0};
      end
      chk("instr_out", instr_out, e_instr);
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_is_c", {31'b0, instr_is_c}, {31'b0, e_c});
      obs_instr.push_back(instr_out);
      obs_pc.push_back(instr_pc);
      obs_c.push_back(instr_is_c);
      obs_cyc.push_back(cyc);
      n_cons++;
      exp_pc = exp_pc + (e_c ? 32'd2 : 32'd4);
    end
    if (deliver) begin
      if (pend_live && !do_flush) exp_fa = exp_fa + 32'd4;
      pend = 0;
    end
    if (accept) begin
      chk("req_addr", req_addr, exp_fa);
      req_log.push_back(req_addr);
      pend      = 1;
      pend_addr = req_addr;
      pend_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
      pend_live = !do_flush;
    end
    if (do_flush) begin
      pend_live = 0;
      exp_pc = {tgt[31:1], 1'b0};
      exp_fa = {tgt[31:2], 2'b00};
    end
  endtask

  task automatic run_obs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (obs_instr.size() < n && k < budget) begin
      tick(0, 32'h0);
      k++;
    end
    if (obs_instr.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, instructions=%0d required=%0d", name, obs_instr.size(), n);
    end
  endtask

  task automatic check_obs(input int idx, input string name, input logic [31:0] ei,
                           input logic [31:0] ep, input logic ec);
    if (idx < obs_instr.size()) begin
      chk({name, "_instr"}, obs_instr[idx], ei);
      chk({name, "_pc"}, obs_pc[idx], ep);
      chk({name, "_c"}, {31'b0, obs_c[idx]}, {31'b0, ec});
    end
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] i0;
    logic [31:0] p0;
    logic [31:0] i1;
    logic [31:0] p1;
    logic        c0;
    logic        c1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] wa;
    int base;
    int base2;
    int k;

    // tgt, word@tgt, next word, instr0, pc0, instr1, pc1, is_c0, is_c1
    vecs[0] = '{32'h100, 32'h4505_4581, 32'h0000_0013, 32'h0000_4581, 32'h100, 32'h0000_4505, 32'h102, 1'b1, 1'b1};
    vecs[1] = '{32'h100, 32'h0093_4505, 32'h0001_0050, 32'h0000_4505, 32'h100, 32'h0050_0093, 32'h102, 1'b1, 1'b0};
    vecs[2] = '{32'h206, 32'h4581_1234, 32'h0050_0093, 32'h0000_4581, 32'h206, 32'h0050_0093, 32'h208, 1'b1, 1'b0};
    vecs[3] = '{32'h802, 32'h0093_ABCD, 32'h4505_0050, 32'h0050_0093, 32'h802, 32'h0000_4505, 32'h806, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFC, 32'h00A0_0113, 32'h4581_4505, 32'h00A0_0113, 32'hFFFF_FFFC, 32'h0000_4505, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{32'h400, 32'h0001_0002, 32'h0000_0013, 32'h0000_0002, 32'h400, 32'h0000_0001, 32'h402, 1'b1, 1'b1};
    vecs[6] = '{32'h901, 32'h00A0_0113, 32'h4581_0001, 32'h00A0_0113, 32'h900, 32'h0000_0001, 32'h904, 1'b0, 1'b1};

    // Reset state and first fetches from RESET_PC.
    mem[32'h100] = 32'h0050_0093;
    mem[32'h104] = 32'h00A0_0113;
    #12;
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_cnt", 32'(dut.cnt), 32'h0);
    @(negedge clk_in);
    rstn_in = 1'b1;
    exp_pc = RST_PC;
    exp_fa = RST_PC;
    clear_obs();
    run_obs(2, 40, "reset_fetch");
    if (req_log.size() >= 2) begin
      chk("reset_req0", req_log[0], 32'h100);
      chk("reset_req1", req_log[1], 32'h104);
    end else begin
      total++;
      bad++;
      $display("FAIL reset_reqs: requests=%0d required=2", req_log.size());
    end
    check_obs(0, "reset_i0", 32'h0050_0093, 32'h100, 1'b0);
    check_obs(1, "reset_i1", 32'h00A0_0113, 32'h104, 1'b0);

    // Table of redirect targets and the first two instructions expected.
    for (int v = 0; v < 7; v++) begin
      wa = {vecs[v].tgt[31:2], 2'b00};
      mem[wa] = vecs[v].w0;
      mem[wa + 32'd4] = vecs[v].w1;
      clear_obs();
      tick(1, vecs[v].tgt);
      run_obs(2, 60, $sformatf("row%0d", v));
      check_obs(0, $sformatf("row%0d_i0", v), vecs[v].i0, vecs[v].p0, vecs[v].c0);
      check_obs(1, $sformatf("row%0d_i1", v), vecs[v].i1, vecs[v].p1, vecs[v].c1);
    end

    // Backpressure: buffer fills to four halfwords, fetching stalls.
    mem[32'h500] = 32'h0050_0093;
    mem[32'h504] = 32'h00A0_0113;
    ir_prob = 0;
    clear_obs();
    tick(1, 32'h500);
    base = req_log.size();
    repeat (20) tick(0, 32'h0);
    chk("bp_requests", 32'(req_log.size() - base), 32'd2);
    chk("bp_cnt", 32'(dut.cnt), 32'd4);
    chk("bp_no_consume", 32'(obs_instr.size()), 32'd0);
    ir_prob = 100;
    run_obs(2, 10, "bp_release");
    check_obs(0, "bp_i0", 32'h0050_0093, 32'h500, 1'b0);
    check_obs(1, "bp_i1", 32'h00A0_0113, 32'h504, 1'b0);
    if (obs_cyc.size() >= 2) chk("bp_back_to_back", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);

    // Stale response: redirect while waiting on 0x104.
    mem[32'h100] = 32'h0050_0093;
    mem[32'h104] = 32'hDEAD_BEEF;
    mem[32'h300] = 32'h00A0_0113;
    lat_lo = 4;
    lat_hi = 4;
    tick(1, 32'h100);
    base = req_log.size();
    k = 0;
    while (req_log.size() < base + 2 && k < 60) begin
      tick(0, 32'h0);
      k++;
    end
    if (req_log.size() >= base + 2) begin
      chk("stale_req_104", req_log[base+1], 32'h104);
    end else begin
      total++;
      bad++;
      $display("FAIL stale_setup: requests=%0d required=2", req_log.size() - base);
    end
    tick(0, 32'h0);
    clear_obs();
    base2 = req_log.size();
    tick(1, 32'h300);
    run_obs(1, 60, "stale_after");
    check_obs(0, "stale_i0", 32'h00A0_0113, 32'h300, 1'b0);
    if (req_log.size() > base2) chk("stale_next_req", req_log[base2], 32'h300);
    else begin
      total++;
      bad++;
      $display("FAIL stale_next_req: no request, required=00000300");
    end

    // Randomized traffic against the stream model.
    lat_lo = 1;
    lat_hi = 4;
    n_cons = 0;
    for (int seg = 0; seg < 8; seg++) begin
      ir_prob = $urandom_range(100, 20);
      rr_prob = $urandom_range(100, 30);
      repeat (500) begin
        if ($urandom_range(99) < 2) tick(1, $urandom());
        else tick(0, 32'h0);
      end
    end
    chk("random_progress", {31'b0, (n_cons >= 200)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
